// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and whoever drives partial re-resets.
// The master side issues sw_req/sw_mask; the slave side (the sequencer) drives the resets and status.
interface reset_sequencer_if #(
    parameter int NUM_CHANNELS = 4
);
    logic                    sw_req;
    logic [NUM_CHANNELS-1:0] sw_mask;
    logic [NUM_CHANNELS-1:0] rst_out;
    logic                    busy;
    logic                    done;
    logic                    req_dropped;

    modport master (
        output sw_req,
        output sw_mask,
        input  rst_out,
        input  busy,
        input  done,
        input  req_dropped
    );

    modport slave (
        input  sw_req,
        input  sw_mask,
        output rst_out,
        output busy,
        output done,
        output req_dropped
    );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronised, stretched and staggered per-channel reset release, with run-time
// partial re-reset of a masked subset of channels.
module reset_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    reset_sequencer_if.slave   bus
);

    localparam int MAX_CYCLES = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] ASSERT_CNT  = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] STAGGER_CNT = CNT_W'(STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        IDLE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]  syncChain_q;
    logic                    syncOut;
    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CHANNELS-1:0] activeMask_q;
    logic [NUM_CHANNELS-1:0] rstOut_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    reqDropped_q;

    logic [NUM_CHANNELS-1:0] lowBit_d;
    logic                    lastChannel_d;
    logic [CNT_W-1:0]        cntInc_d;
    logic                    releaseNow_d;
    logic                    reqAccept_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign syncOut = syncChain_q[SYNC_STAGES-1];

    // activeMask_q holds the channels still waiting to be released; its lowest set bit goes next.
    always_comb begin
        lowBit_d      = activeMask_q & (~activeMask_q + NUM_CHANNELS'(1));
        lastChannel_d = ((activeMask_q & ~lowBit_d) == '0);
        cntInc_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
        releaseNow_d  = ((state_q == HOLD) && syncOut && (cnt_q >= ASSERT_CNT)) ||
                        ((state_q == RELEASE) && (cnt_q >= STAGGER_CNT));
        reqAccept_d   = bus.sw_req && (state_q == IDLE) && (bus.sw_mask != '0);
    end

    // The counter restarts at one because the edge that starts a wait is itself its first cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            activeMask_q <= '1;
            rstOut_q     <= '1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            reqDropped_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            reqDropped_q <= bus.sw_req && busy_q;

            if (releaseNow_d) begin
                rstOut_q     <= rstOut_q & ~lowBit_d;
                activeMask_q <= activeMask_q & ~lowBit_d;
                cnt_q        <= CNT_ONE;
                if (lastChannel_d) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= RELEASE;
                end
            end else begin
                case (state_q)
                    HOLD: begin
                        if (syncOut) begin
                            cnt_q <= cntInc_d;
                        end
                    end
                    RELEASE: begin
                        cnt_q <= cntInc_d;
                    end
                    IDLE: begin
                        if (reqAccept_d) begin
                            activeMask_q <= bus.sw_mask;
                            rstOut_q     <= rstOut_q | bus.sw_mask;
                            cnt_q        <= CNT_ONE;
                            busy_q       <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                    default: begin
                        state_q <= HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out     = rstOut_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.req_dropped = reqDropped_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected per-edge output snapshots are queued when stimulus is applied
// and compared on the falling edge after the matching rising edge.
module tb_reset_sequencer;

    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int A   = 16;
    localparam int ST  = 4;

    typedef struct {
        int         edgeNo;
        string      tag;
        logic [6:0] exp;
        bit         sweep;
    } expEntry_t;

    logic clock;
    logic reset;
    logic resetSweep;
    int   cyc;
    int   totalChecks;
    int   badChecks;

    expEntry_t sbQ[$];
    expEntry_t monEntry;

    reset_sequencer_if #(.NUM_CHANNELS(NCH)) busMain ();
    reset_sequencer_if #(.NUM_CHANNELS(1))   busSweep ();

    reset_sequencer #(
        .NUM_CHANNELS(NCH),
        .SYNC_STAGES(S),
        .ASSERT_CYCLES(A),
        .STAGGER_CYCLES(ST)
    ) dutMain (
        .clock(clock),
        .reset(reset),
        .bus(busMain)
    );

    reset_sequencer #(
        .NUM_CHANNELS(1),
        .SYNC_STAGES(3),
        .ASSERT_CYCLES(1),
        .STAGGER_CYCLES(1)
    ) dutSweep (
        .clock(clock),
        .reset(resetSweep),
        .bus(busSweep)
    );

    logic [6:0] mainObs;
    logic [6:0] sweepObs;
    assign mainObs  = {busMain.rst_out, busMain.busy, busMain.done, busMain.req_dropped};
    assign sweepObs = {3'b000, busSweep.rst_out, busSweep.busy, busSweep.done, busSweep.req_dropped};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [NCH-1:0] mask);
        busMain.sw_req  = req;
        busMain.sw_mask = mask;
    endtask

    task automatic waitUntil(input int edgeNo);
        while (cyc < edgeNo) @(negedge clock);
    endtask

    function automatic void pushExp(input int edgeNo, input string tag, input logic [6:0] exp, input bit sweep);
        expEntry_t ent;
        ent.edgeNo = edgeNo;
        ent.tag    = tag;
        ent.exp    = exp;
        ent.sweep  = sweep;
        sbQ.push_back(ent);
    endfunction

    // Channel k falls on edge S + A + k*ST; done and busy follow the last channel.
    function automatic void pushPowerOn(input int base, input int dropRel, input string name);
        for (int e = 0; e <= 34; e++) begin
            logic [NCH-1:0] r;
            for (int k = 0; k < NCH; k++) r[k] = (e < S + A + k * ST);
            pushExp(base + e, $sformatf("%s_e%0d", name, e),
                    {r, 1'(e < S + A + (NCH - 1) * ST), 1'(e == S + A + (NCH - 1) * ST), 1'(e == dropRel)}, 1'b0);
        end
    endfunction

    // Re-reset of mask 1010 requested at edge T: channel 1 at T+A, channel 3 at T+A+ST.
    function automatic void pushPartial(input int base, input int dropRel, input int lastRel, input string name);
        for (int e = 0; e <= lastRel; e++) begin
            logic [NCH-1:0] r;
            r = {1'(e < A + ST), 1'b0, 1'(e < A), 1'b0};
            pushExp(base + e, $sformatf("%s_e%0d", name, e),
                    {r, 1'(e < A + ST), 1'(e == A + ST), 1'(e == dropRel)}, 1'b0);
        end
    endfunction

    always @(negedge clock) begin
        while (sbQ.size() > 0 && sbQ[0].edgeNo <= cyc) begin
            monEntry = sbQ.pop_front();
            if (monEntry.edgeNo < cyc)
                checkOutput({monEntry.tag, "_missed"}, 32'(cyc), 32'(monEntry.edgeNo));
            else if (monEntry.sweep)
                checkOutput(monEntry.tag, 32'(sweepObs), 32'(monEntry.exp));
            else
                checkOutput(monEntry.tag, 32'(mainObs), 32'(monEntry.exp));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t;
        cyc         = 0;
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b0;
        resetSweep  = 1'b0;
        busSweep.sw_req  = 1'b0;
        busSweep.sw_mask = 1'b0;
        applyStimulus(1'b0, '0);

        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_state", 32'(mainObs), 32'(7'b1111_1_0_0));

        $display("[TB] power-on with rejected request at edge 25");
        base = cyc + 1;
        pushPowerOn(base, 25, "poweron");
        reset = 1'b1;
        waitUntil(base + 24);
        applyStimulus(1'b1, 4'b0101);
        @(negedge clock);
        applyStimulus(1'b0, '0);
        waitUntil(base + 35);

        $display("[TB] partial re-reset 1010 with request on last release edge");
        t = cyc + 1;
        pushPartial(t, A + ST, 24, "partial");
        applyStimulus(1'b1, 4'b1010);
        @(negedge clock);
        applyStimulus(1'b0, '0);
        waitUntil(t + A + ST - 1);
        applyStimulus(1'b1, 4'b0001);
        @(negedge clock);
        applyStimulus(1'b0, '0);
        waitUntil(t + 25);

        $display("[TB] zero-mask request");
        t = cyc + 1;
        for (int e = 0; e < 40; e++) pushExp(t + e, $sformatf("zeromask_e%0d", e), 7'b0000_0_0_0, 1'b0);
        applyStimulus(1'b1, 4'b0000);
        @(negedge clock);
        applyStimulus(1'b0, '0);
        waitUntil(t + 40);

        $display("[TB] reset during partial re-reset");
        t = cyc + 1;
        pushPartial(t, -1, A + 1, "midseq");
        applyStimulus(1'b1, 4'b1010);
        @(negedge clock);
        applyStimulus(1'b0, '0);
        waitUntil(t + A + 1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 32'(mainObs), 32'(7'b1111_1_0_0));
        repeat (3) @(negedge clock);
        base = cyc + 1;
        pushPowerOn(base, -1, "repoweron");
        reset = 1'b1;
        waitUntil(base + 35);

        $display("[TB] parameter sweep N=1 S=3 A=1 ST=1");
        checkOutput("sweep_reset", 32'(sweepObs), 32'(7'b000_1_1_0_0));
        base = cyc + 1;
        for (int e = 0; e <= 7; e++)
            pushExp(base + e, $sformatf("sweep_e%0d", e), {3'b000, 1'(e < 4), 1'(e < 4), 1'(e == 4), 1'b0}, 1'b1);
        resetSweep = 1'b1;
        waitUntil(base + 8);

        @(negedge clock);
        checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
